// File: rtl/instr_prefetch_fifo.sv
// instr_prefetch_fifo
//   Prefetches instruction bytes from external SPI RAM ahead of the 4-bit
//   execute FSM. Up to DEPTH bytes are buffered, and opcodes are handed out
//   one nibble at a time, low nibble first. A flush redirects fetching to a
//   new byte address and throws away buffered and in-flight data.
//
//   Build option: define PREFETCH_STATS_EN to add the stall_cnt output.
//
// Ports
//   clk_pc      clock, all state on posedge
//   rst_n       synchronous active-low reset
//   spi_start   one-cycle read request (registered)
//   spi_addr    read byte address, zero-extended fetch pointer
//   spi_busy    SPI reader busy, blocks new requests
//   spi_done    read complete, spi_data valid this cycle
//   spi_data    fetched byte
//   op_valid    opcode holds a valid nibble
//   op_ready    consumer takes opcode this cycle
//   opcode      head nibble
//   op_addr     nibble address {byte address, nibble select}
//   flush       redirect request
//   flush_addr  byte address to resume fetching from
//   fill        bytes currently buffered
//   stall_cnt   (PREFETCH_STATS_EN) cycles the consumer waited on an empty buffer
//
// state   | meaning
// S_IDLE  | no read outstanding
// S_WAIT  | read outstanding, result kept
// S_DRAIN | read outstanding, result discarded
module instr_prefetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic                   clk_pc,
  input  logic                   rst_n,
  output logic                   spi_start,
  output logic [15:0]            spi_addr,
  input  logic                   spi_busy,
  input  logic                   spi_done,
  input  logic [7:0]             spi_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [3:0]             opcode,
  output logic [ADDR_W:0]        op_addr,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  output logic [$clog2(DEPTH):0] fill
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   issue_pc;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                nib_sel;
  logic                push;
  logic                hs;
  logic                pop;
  logic                issue;
  logic [FILL_W-1:0]   fill_nxt;
  logic [7:0]          mem_data [DEPTH];
  logic [ADDR_W-1:0]   mem_addr [DEPTH];
  logic [7:0]          head;

  assign pc_inc   = fetch_pc + 1'b1;
  assign op_valid = (fill != '0);
  assign push     = (state == S_WAIT) && spi_done && !flush;
  assign hs       = op_valid && op_ready && !flush;
  assign pop      = hs && nib_sel;
  assign fill_nxt = fill + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  assign head    = mem_data[rd_ptr];
  assign opcode  = op_valid ? (nib_sel ? head[7:4] : head[3:0]) : 4'h0;
  assign op_addr = op_valid ? {mem_addr[rd_ptr], nib_sel} : '0;

  // A read completing in S_WAIT may immediately be followed by the next one;
  // the space check then uses the fill after this cycle's push/pop so that
  // buffered plus in-flight bytes never exceed DEPTH.
  always_comb begin
    issue    = 1'b0;
    issue_pc = fetch_pc;
    if (!flush && !spi_busy) begin
      if (state == S_IDLE) begin
        issue = (fill < FULL);
      end else if (state == S_WAIT && spi_done) begin
        issue    = (fill_nxt < FULL);
        issue_pc = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_pc) begin
    if (push) begin
      mem_data[wr_ptr] <= spi_data;
      mem_addr[wr_ptr] <= fetch_pc;
    end
  end

  always_ff @(posedge clk_pc) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      spi_start <= 1'b0;
      spi_addr  <= 16'h0000;
      fetch_pc  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      nib_sel   <= 1'b0;
    end else begin
      spi_start <= issue;
      if (issue) begin
        spi_addr <= 16'(issue_pc);
      end
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fill     <= '0;
        nib_sel  <= 1'b0;
        fetch_pc <= flush_addr;
        // A read still open after this edge must be drained; one that
        // completes in the flush cycle is simply dropped.
        if (state != S_IDLE && !spi_done) begin
          state <= S_DRAIN;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        fill <= fill_nxt;
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          fetch_pc <= pc_inc;
        end
        if (hs) begin
          if (nib_sel) begin
            rd_ptr  <= rd_ptr + 1'b1;
            nib_sel <= 1'b0;
          end else begin
            nib_sel <= 1'b1;
          end
        end
        case (state)
          S_IDLE: begin
            if (issue) state <= S_WAIT;
          end
          S_WAIT: begin
            if (spi_done) state <= issue ? S_WAIT : S_IDLE;
          end
          S_DRAIN: begin
            if (spi_done) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk_pc) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (op_ready && !op_valid && !flush && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_fifo.sv
// Testbench for instr_prefetch_fifo. An SPI RAM model answers read requests;
// every accepted read pushes the two nibbles the consumer must later see into
// a scoreboard queue, and a monitor pops and compares on each handshake.
module tb_instr_prefetch_fifo;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;

  logic        clk_pc = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_start;
  logic [15:0] spi_addr;
  logic        spi_busy = 1'b0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_data = 8'h00;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [3:0]  opcode;
  logic [12:0] op_addr;
  logic        flush = 1'b0;
  logic [11:0] flush_addr = 12'h000;
  logic [2:0]  fill;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk_pc = ~clk_pc;

  instr_prefetch_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_pc     (clk_pc),
    .rst_n      (rst_n),
    .spi_start  (spi_start),
    .spi_addr   (spi_addr),
    .spi_busy   (spi_busy),
    .spi_done   (spi_done),
    .spi_data   (spi_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .opcode     (opcode),
    .op_addr    (op_addr),
    .flush      (flush),
    .flush_addr (flush_addr),
    .fill       (fill)
`ifdef PREFETCH_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [12:0] addr;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mem [4096];

  // stimulus knobs
  int          ready_mode = 0;   // 0 low, 1 high, 2 random
  bit          hold_busy = 1'b0;
  int          busy_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          flush_pct = 0;
  bit          req_flush = 1'b0;
  logic [11:0] req_flush_addr = 12'h000;
  bit          flush_on_done = 1'b0;
  logic [11:0] fod_addr = 12'h000;

  // observation
  int          cyc = 0;
  int          flush_cyc = -10;
  int          start_cnt = 0;
  logic [15:0] last_start_addr = 16'h0000;
  bit          cap_first = 1'b0;
  bit          first_got = 1'b0;
  logic [3:0]  first_op = 4'h0;
  logic [12:0] first_addr = 13'h0000;

  // reference model of the fetch stream
  logic [11:0] model_pc = 12'h000;
  bit          inflight = 1'b0;
  bit          inflight_ok = 1'b0;
  int          lat_cnt = 0;
  logic [11:0] rd_addr = 12'h000;
  bit          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver / SPI RAM model: acts 1 time unit after each rising edge.
  always @(posedge clk_pc) begin
    bit          started;
    bit          done_now;
    bit          do_flush;
    bit          fod_fire;
    logic [11:0] fa;
    logic [7:0]  b;
    #1;
    cyc++;
    started  = 1'b0;
    done_now = 1'b0;
    do_flush = 1'b0;
    fod_fire = 1'b0;
    fa       = 12'h000;
    if (!rst_n) begin
      model_pc = 12'h000;
      inflight = 1'b0;
      exp_q.delete();
      spi_done = 1'b0;
      flush    = 1'b0;
      spi_busy = hold_busy;
    end else begin
      if (spi_start) begin
        chk("spi_start_gating", 32'({prev_busy, inflight}), 32'h0);
        chk("spi_addr", 32'(spi_addr), 32'({4'h0, model_pc}));
        inflight        = 1'b1;
        inflight_ok     = 1'b1;
        lat_cnt         = $urandom_range(lat_max, lat_min);
        rd_addr         = spi_addr[11:0];
        last_start_addr = spi_addr;
        start_cnt++;
        started = 1'b1;
      end
      if (inflight && !started) begin
        lat_cnt--;
        if (lat_cnt <= 0) done_now = 1'b1;
      end
      if (req_flush) begin
        do_flush  = 1'b1;
        fa        = req_flush_addr;
        req_flush = 1'b0;
      end else if (flush_on_done && done_now) begin
        do_flush      = 1'b1;
        fod_fire      = 1'b1;
        fa            = fod_addr;
        flush_on_done = 1'b0;
      end else if (flush_pct > 0 && $urandom_range(99, 0) < flush_pct) begin
        do_flush = 1'b1;
        fa       = ($urandom_range(3, 0) == 0) ? 12'hFFF : 12'($urandom);
      end
      if (do_flush) begin
        model_pc    = fa;
        inflight_ok = 1'b0;
        exp_q.delete();
        flush_cyc   = cyc;
      end
      if (done_now) begin
        spi_done = 1'b1;
        spi_data = mem[rd_addr];
        inflight = 1'b0;
        if (!do_flush && inflight_ok) begin
          b = mem[model_pc];
          exp_q.push_back('{op: b[3:0], addr: {model_pc, 1'b0}});
          exp_q.push_back('{op: b[7:4], addr: {model_pc, 1'b1}});
          model_pc = model_pc + 12'h001;
        end
      end else begin
        spi_done = 1'b0;
        spi_data = 8'($urandom);
      end
      flush      = do_flush;
      flush_addr = do_flush ? fa : 12'($urandom);
      spi_busy   = hold_busy || inflight ||
                   (busy_pct > 0 && $urandom_range(99, 0) < busy_pct);
    end
    prev_busy = spi_busy;
    case (ready_mode)
      0:       op_ready = 1'b0;
      1:       op_ready = 1'b1;
      default: op_ready = ($urandom_range(1, 0) == 1);
    endcase
    if (fod_fire) op_ready = 1'b1;
  end

  // Monitor: compares the presented opcode against the scoreboard on handshakes.
  always @(negedge clk_pc) begin
    exp_t e;
    if (rst_n && op_valid && !flush) begin
      chk("op_valid_without_data", 32'(exp_q.size() == 0), 32'h0);
      if (op_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("op_addr", 32'(op_addr), 32'(e.addr));
        if (cap_first) begin
          first_op   = opcode;
          first_addr = op_addr;
          first_got  = 1'b1;
          cap_first  = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_pc);
    chk("rst_spi_start", 32'(spi_start), 32'h0);
    chk("rst_spi_addr", 32'(spi_addr), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_op_addr", 32'(op_addr), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    hold_busy  = 1'b1;
    ready_mode = 1;
    flush_pct  = 0;
    busy_pct   = 0;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || op_valid || inflight); i++)
      @(negedge clk_pc);
    chk("drain_left", 32'(exp_q.size()), 32'h0);
    hold_busy = 1'b0;
  endtask

  task automatic capture_first(input string name, input logic [3:0] e_op, input logic [12:0] e_addr);
    for (int i = 0; i < 100 && !first_got; i++) @(negedge clk_pc);
    chk({name, "_seen"}, 32'(first_got), 32'h1);
    chk({name, "_opcode"}, 32'(first_op), 32'(e_op));
    chk({name, "_op_addr"}, 32'(first_addr), 32'(e_addr));
  endtask

  task automatic send_flush(input logic [11:0] a);
    req_flush_addr = a;
    req_flush      = 1'b1;
    for (int i = 0; i < 10 && req_flush; i++) @(negedge clk_pc);
    chk("flush_taken", 32'(req_flush), 32'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    // basic fetch of one byte, low nibble first
    mem[0] = 8'h21;
    ready_mode = 1;
    do_reset();
    first_got = 1'b0;
    cap_first = 1'b1;
    capture_first("first_fetch", 4'h1, 13'h0000);
    drain();

    // fill to DEPTH with no consumer, then release one byte
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'h10 + i);
    ready_mode = 0;
    do_reset();
    base = start_cnt;
    repeat (40) @(negedge clk_pc);
    chk("full_start_count", 32'(start_cnt - base), 32'd4);
    chk("full_fill", 32'(fill), 32'd4);
    ready_mode = 1;
    repeat (2) @(negedge clk_pc);
    ready_mode = 0;
    for (int i = 0; i < 10 && start_cnt - base < 5; i++) @(negedge clk_pc);
    chk("refill_start_count", 32'(start_cnt - base), 32'd5);
    chk("refill_addr", 32'(last_start_addr), 32'h0004);
    drain();

    // flush to the top of the address space, fetch wraps to 0
    mem[12'hFFF] = 8'hBA;
    mem[12'h000] = 8'hDC;
    hold_busy = 1'b1;
    ready_mode = 1;
    do_reset();
    send_flush(12'hFFF);
    hold_busy = 1'b0;
    first_got = 1'b0;
    cap_first = 1'b1;
    capture_first("wrap_flush", 4'hA, 13'h1FFE);
    repeat (20) @(negedge clk_pc);
    drain();

    // flush while a read is outstanding: its byte must never appear
    mem[12'h000] = 8'h55;
    mem[12'h040] = 8'h98;
    lat_min = 6;
    lat_max = 6;
    ready_mode = 1;
    do_reset();
    base = start_cnt;
    for (int i = 0; i < 20 && start_cnt == base; i++) @(negedge clk_pc);
    chk("pending_read_issued", 32'(start_cnt - base), 32'd1);
    first_got = 1'b0;
    cap_first = 1'b1;
    send_flush(12'h040);
    capture_first("drain_flush", 4'h8, 13'h0080);
    drain();

    // flush colliding with spi_done and a handshake
    lat_min = 3;
    lat_max = 3;
    ready_mode = 0;
    do_reset();
    for (int i = 0; i < 50 && fill == 0; i++) @(negedge clk_pc);
    chk("collide_prefill", 32'(fill != 0), 32'h1);
    base = flush_cyc;
    fod_addr = 12'h123;
    flush_on_done = 1'b1;
    for (int i = 0; i < 50 && flush_cyc == base; i++) @(negedge clk_pc);
    chk("collide_flush_fired", 32'(flush_cyc != base), 32'h1);
    for (int i = 0; i < 5 && cyc != flush_cyc + 1; i++) @(negedge clk_pc);
    chk("collide_fill", 32'(fill), 32'h0);
    chk("collide_op_valid", 32'(op_valid), 32'h0);
    base = start_cnt;
    ready_mode = 1;
    for (int i = 0; i < 20 && start_cnt == base; i++) @(negedge clk_pc);
    chk("collide_next_addr", 32'(last_start_addr), 32'h0123);
    drain();

    // randomized traffic, then a reset in the middle of it
    lat_min = 1;
    lat_max = 4;
    do_reset();
    ready_mode = 2;
    busy_pct = 20;
    flush_pct = 3;
    repeat (3000) @(negedge clk_pc);
    do_reset();
    ready_mode = 2;
    busy_pct = 20;
    repeat (500) @(negedge clk_pc);
    drain();

`ifdef PREFETCH_STATS_EN
    hold_busy = 1'b1;
    ready_mode = 1;
    do_reset();
    repeat (20) @(negedge clk_pc);
    chk("stall_cnt_20", 32'(stall_cnt), 32'd20);
    repeat (65540) @(negedge clk_pc);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
    hold_busy = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
